seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
- Parametrised sequential multiplier built from repeated addition: controller FSM plus operand, counter and product datapath in one block.
- Successor to the fixed 3-bit load/decrement controller. Adds generic WIDTH, a start/busy/done handshake, abort, return-to-idle after completion and optional operand swap to shorten the loop.
- Sits between a host sequencer (issues start and operands) and downstream logic that consumes product on done.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- SWAP_SMALLER, 1. When 1, the smaller operand becomes the loop count; when 0, b_in is always the count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel operation in progress.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- busy  out  1  high in LOAD and ADD.
- done  out  1  single-cycle completion pulse (DONE state).
- product  out  2*WIDTH  product register P.
- ld_a  out  1  strobe: A register loads (LOAD state).
- ld_b  out  1  strobe: B counter loads (LOAD state).
- clr  out  1  strobe: P cleared (LOAD state).
- ld_p  out  1  strobe: P <= P + A this cycle.
- dec  out  1  strobe: B <= B - 1 this cycle.
- eqz  out  1  B counter == 0 (combinational from B).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; A, B and P = 0; busy, done, ld_a, ld_b, clr, ld_p and dec = 0; eqz = 1.
- States: IDLE, LOAD, ADD, DONE. Any unencoded state goes to IDLE on the next edge.
- Strobes and busy/done are Moore outputs decoded from state, except ld_p/dec, which also depend on eqz.
- IDLE:
  - start=1 -> LOAD; otherwise stay.
  - abort is ignored in IDLE.
- LOAD:
  - ld_a=ld_b=clr=1, busy=1.
  - At the end of the cycle, A and B capture the operands and P <= 0.
  - If SWAP_SMALLER=1 and a_in < b_in: A <= b_in, B <= a_in. Otherwise A <= a_in, B <= b_in.
  - a_in/b_in must be held stable from the start cycle through LOAD.
  - Next state is ADD.
- ADD:
  - busy=1.
  - If eqz=1 -> DONE, and ld_p=dec=0.
  - Else ld_p=dec=1: P <= P + zero-extended A, B <= B - 1; stay in ADD.
- DONE:
  - done=1, busy=0; product holds the final value.
  - Next state is IDLE unconditionally.
  - start asserted during DONE is ignored; it must be re-presented in IDLE.
- Latency: with start high in IDLE at cycle t, LOAD=t+1, ADD=t+2..t+2+n, DONE=t+3+n.
  - n = min(a,b) if SWAP_SMALLER=1, else b.
  - Zero count gives done at t+3.
- Arithmetic:
  - P is 2*WIDTH bits and never overflows, since P <= (2^WIDTH-1)^2.
  - B never decrements below 0.
- Product hold: product is stable from DONE until the end of the next LOAD (cleared by clr). It is valid to read it while in IDLE.
- start while busy: ignored; it has no effect on operands or state.
- abort=1 in LOAD or ADD:
  - Next state is IDLE and P <= 0.
  - done is not asserted; strobes are 0 from the next cycle.
  - abort has priority over the eqz transition.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Back-to-back: the earliest next start is the IDLE cycle after DONE, so minimum spacing between done pulses is n+4 cycles.

Test Plan:
- WIDTH=16, SWAP_SMALLER=1, a=3, b=5, start at t:
  - Required: LOAD at t+1, exactly 3 ld_p/dec pulses.
  - done at t+6 for one cycle; product=15.
  - busy high t+1..t+5; eqz=1 at t+5.
- Same a=3, b=5 with SWAP_SMALLER=0 -> 5 add cycles, done at t+8, product=15.
- a=0x1234, b=0:
  - Required: zero add cycles, done at t+3, product=0.
- Swap check: a=0, b=0xFFFF with SWAP_SMALLER=1 -> done at t+3, product=0.
- WIDTH=4, a=15, b=15 -> 15 add cycles, done at t+18, product=225 (8'hE1).
- start pulsed during ADD with different operands -> ignored; original product delivered.
- abort at the 2nd ADD cycle of 7x9 -> IDLE next cycle, product=0, no done.
- Reset asserted mid-ADD -> all outputs reset immediately.
- Then a fresh 2x2 completes with product=4.
- Two back-to-back 2x3 operations, the second start in the first IDLE after DONE -> done pulses 6 cycles apart, both products = 6.

Source files
------------

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: sequential multiplier built from repeated addition.
// A four-state controller (IDLE/LOAD/ADD/DONE) drives an operand register A,
// a down-counter B and a 2*WIDTH product register P. With SWAP_SMALLER set,
// the smaller operand becomes the loop count so the add loop is as short as
// possible.
module seq_mult_unit #(
   parameter int WIDTH        = 16,
   parameter int SWAP_SMALLER = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 ld_a,
   output logic                 ld_b,
   output logic                 clr,
   output logic                 ld_p,
   output logic                 dec,
   output logic                 eqz
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [WIDTH-1:0]      a_r;
   logic [WIDTH-1:0]      b_r;
   logic [2*WIDTH-1:0]    p_r;
   logic                  swap_s;
   logic                  abort_s;
   logic [WIDTH-1:0]      a_load_s;
   logic [WIDTH-1:0]      b_load_s;

   // B counter reaching zero ends the add loop.
   assign eqz     = (b_r == {WIDTH{1'b0}});
   assign product = p_r;

   // Operand steering: the smaller operand becomes the loop count when enabled.
   always_comb begin
      swap_s   = 1'b0;
      a_load_s = a_in;
      b_load_s = b_in;
      if ((SWAP_SMALLER != 0) && (a_in < b_in)) begin
         swap_s   = 1'b1;
         a_load_s = b_in;
         b_load_s = a_in;
      end else begin
         swap_s   = 1'b0;
         a_load_s = a_in;
         b_load_s = b_in;
      end
   end

   // Abort only takes effect while an operation is in flight.
   always_comb begin
      if ((state_r == S_LOAD) || (state_r == S_ADD)) begin
         abort_s = abort;
      end else begin
         abort_s = 1'b0;
      end
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and Moore strobes; ld_p/dec additionally follow eqz.
   always_comb begin
      state_s = S_IDLE;
      busy    = 1'b0;
      done    = 1'b0;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      clr     = 1'b0;
      ld_p    = 1'b0;
      dec     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_LOAD;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOAD: begin
            busy = 1'b1;
            ld_a = 1'b1;
            ld_b = 1'b1;
            clr  = 1'b1;
            if (abort) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_ADD;
            end
         end
         S_ADD: begin
            busy = 1'b1;
            if (eqz) begin
               ld_p = 1'b0;
               dec  = 1'b0;
            end else begin
               ld_p = 1'b1;
               dec  = 1'b1;
            end
            if (abort) begin
               state_s = S_IDLE;
            end else if (eqz) begin
               state_s = S_DONE;
            end else begin
               state_s = S_ADD;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, accumulate and count down; abort clears P.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r <= {WIDTH{1'b0}};
         b_r <= {WIDTH{1'b0}};
         p_r <= {(2*WIDTH){1'b0}};
      end else if (abort_s) begin
         p_r <= {(2*WIDTH){1'b0}};
      end else begin
         if (ld_a) begin
            a_r <= a_load_s;
         end
         if (ld_b) begin
            b_r <= b_load_s;
         end
         if (clr) begin
            p_r <= {(2*WIDTH){1'b0}};
         end else if (ld_p) begin
            p_r <= p_r + {{WIDTH{1'b0}}, a_r};
         end
         if (dec) begin
            b_r <= b_r - {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: three instances (16-bit swap, 16-bit no-swap,
// 4-bit swap) checked every cycle against a timeline model derived from the
// operation's cycle index, plus directed literal expectations.
module tb_seq_mult_unit;

   logic clk;
   logic rst;
   logic st [3];
   logic ab [3];
   logic [15:0] av [3];
   logic [15:0] bv [3];
   logic [2:0] busy_v, done_v, lda_v, ldb_v, clr_v, ldp_v, dec_v, eqz_v;
   logic [31:0] p0, p1;
   logic [7:0]  p2;

   int checks = 0;
   int passes = 0;
   int ldp_cnt [3];

   // model state: k = cycle index of current op (0 idle, 1 LOAD, 2.. ADD, n+3 DONE)
   int     mk [3];
   int     mn [3];
   longint ma [3];
   longint hp [3];
   longint hr [3];
   int     wid [3];
   int     swp [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_mult_unit #(.WIDTH(16), .SWAP_SMALLER(1)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .a_in(av[0]), .b_in(bv[0]),
      .busy(busy_v[0]), .done(done_v[0]), .product(p0), .ld_a(lda_v[0]), .ld_b(ldb_v[0]),
      .clr(clr_v[0]), .ld_p(ldp_v[0]), .dec(dec_v[0]), .eqz(eqz_v[0]));
   seq_mult_unit #(.WIDTH(16), .SWAP_SMALLER(0)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .a_in(av[1]), .b_in(bv[1]),
      .busy(busy_v[1]), .done(done_v[1]), .product(p1), .ld_a(lda_v[1]), .ld_b(ldb_v[1]),
      .clr(clr_v[1]), .ld_p(ldp_v[1]), .dec(dec_v[1]), .eqz(eqz_v[1]));
   seq_mult_unit #(.WIDTH(4), .SWAP_SMALLER(1)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]), .a_in(av[2][3:0]), .b_in(bv[2][3:0]),
      .busy(busy_v[2]), .done(done_v[2]), .product(p2), .ld_a(lda_v[2]), .ld_b(ldb_v[2]),
      .clr(clr_v[2]), .ld_p(ldp_v[2]), .dec(dec_v[2]), .eqz(eqz_v[2]));

   function automatic logic [7:0] ctl(input int i);
      return {busy_v[i], done_v[i], lda_v[i], ldb_v[i], clr_v[i], ldp_v[i], dec_v[i], eqz_v[i]};
   endfunction

   function automatic longint prod(input int i);
      if (i == 0) return longint'(p0);
      else if (i == 1) return longint'(p1);
      else return longint'(p2);
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
   endtask

   // Model update on each clock edge (and asynchronously on reset).
   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            mk[i] = 0; hp[i] = 0; hr[i] = 0; mn[i] = 0; ma[i] = 0;
         end else if (mk[i] == 0) begin
            if (st[i]) begin
               longint a, b, m;
               m = (longint'(1) << wid[i]) - 1;
               a = longint'(av[i]) & m;
               b = longint'(bv[i]) & m;
               mk[i] = 1;
               if (swp[i] != 0 && a < b) begin ma[i] = b; mn[i] = int'(a); end
               else begin ma[i] = a; mn[i] = int'(b); end
            end
         end else if (mk[i] == 1) begin
            if (ab[i]) begin mk[i] = 0; hp[i] = 0; end
            else mk[i] = 2;
         end else if (mk[i] <= mn[i] + 2) begin
            longint rem;
            rem = longint'(mn[i] - (mk[i] - 2));
            if (ab[i]) begin mk[i] = 0; hp[i] = 0; hr[i] = rem; end
            else if (rem == 0) mk[i] = mn[i] + 3;
            else mk[i] = mk[i] + 1;
         end else begin
            mk[i] = 0; hp[i] = ma[i] * longint'(mn[i]); hr[i] = 0;
         end
      end
   end

   // Compare every instance against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            logic [7:0] ev;
            longint     ep, rem;
            int         k;
            k = mk[i];
            if (k == 0) begin
               ev = {7'b0000000, (hr[i] == 0) ? 1'b1 : 1'b0}; ep = hp[i];
            end else if (k == 1) begin
               ev = {5'b10111, 2'b00, (hr[i] == 0) ? 1'b1 : 1'b0}; ep = hp[i];
            end else if (k <= mn[i] + 2) begin
               rem = longint'(mn[i] - (k - 2));
               ev = (rem == 0) ? 8'b1000_0001 : 8'b1000_0110;
               ep = ma[i] * longint'(k - 2);
            end else begin
               ev = 8'b0100_0001; ep = ma[i] * longint'(mn[i]);
            end
            check($sformatf("ctl%0d", i), longint'(ctl(i)), longint'(ev));
            check($sformatf("prod%0d", i), prod(i), ep);
            ldp_cnt[i] += int'(ldp_v[i]);
         end
      end
   end

   task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input longint expp, input int expc, output time td);
      int c;
      @(posedge clk); #2; st[i] = 1'b1; av[i] = a; bv[i] = b;
      @(posedge clk); #2; st[i] = 1'b0; c = 1;
      while (c < 60) begin
         @(negedge clk);
         if (done_v[i]) break;
         @(posedge clk); #2; c++;
      end
      td = $time;
      check($sformatf("done_cycle%0d", i), longint'(c), longint'(expc));
      check($sformatf("done_prod%0d", i), prod(i), expp);
   endtask

   initial begin
      time t1, t2;
      int  c0, seen;
      wid[0] = 16; wid[1] = 16; wid[2] = 4;
      swp[0] = 1;  swp[1] = 0;  swp[2] = 1;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; ab[i] = 1'b0; av[i] = 16'h0; bv[i] = 16'h0; ldp_cnt[i] = 0;
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2; rst = 1'b1;
      @(negedge clk);
      check("reset_ctl", longint'(ctl(0)), longint'(8'h01));
      check("reset_prod", prod(0), 0);

      c0 = ldp_cnt[0];
      run_op(0, 16'd3, 16'd5, 15, 6, t1);
      check("ldp_pulses", longint'(ldp_cnt[0] - c0), 3);
      run_op(1, 16'd3, 16'd5, 15, 8, t1);
      run_op(0, 16'h1234, 16'h0000, 0, 3, t1);
      run_op(0, 16'h0000, 16'hFFFF, 0, 3, t1);
      run_op(2, 16'd15, 16'd15, 225, 18, t1);

      // start with other operands while busy must be ignored
      fork
         run_op(0, 16'd4, 16'd6, 24, 7, t1);
         begin
            repeat (4) @(posedge clk);
            #3; st[0] = 1'b1; av[0] = 16'd9; bv[0] = 16'd9;
            @(posedge clk); #3; st[0] = 1'b0;
         end
      join

      // abort in the second ADD cycle of 7x9
      @(posedge clk); #2; st[0] = 1'b1; av[0] = 16'd7; bv[0] = 16'd9;
      @(posedge clk); #2; st[0] = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2; ab[0] = 1'b1;
      @(negedge clk);
      check("abort_pre_prod", prod(0), 9);
      @(posedge clk); #2; ab[0] = 1'b0;
      @(negedge clk);
      check("abort_busy", longint'(busy_v[0]), 0);
      check("abort_prod", prod(0), 0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_v[0]) seen = 1;
      end
      check("abort_no_done", longint'(seen), 0);

      // reset in the middle of ADD
      @(posedge clk); #2; st[0] = 1'b1; av[0] = 16'd7; bv[0] = 16'd9;
      @(posedge clk); #2; st[0] = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2; rst = 1'b0;
      #1;
      check("midrst_ctl", longint'(ctl(0)), longint'(8'h01));
      check("midrst_prod", prod(0), 0);
      @(posedge clk); #2; rst = 1'b1;
      run_op(0, 16'd2, 16'd2, 4, 5, t1);

      // back-to-back 2x3: second start in the first IDLE after DONE
      run_op(0, 16'd2, 16'd3, 6, 5, t1);
      run_op(0, 16'd2, 16'd3, 6, 5, t2);
      check("b2b_spacing", longint'((t2 - t1) / 10), 6);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
